// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared core package: RV32I major opcodes, the default NOP word, the loader
// FSM state encoding and the byte-stream format constants.
// No ports (package).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int WORD_W = 32;

  // RV32I major opcodes (bits 6:0 of every instruction)
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0 : the canonical RISC-V NOP (32'h00000013)
  localparam logic [WORD_W-1:0] DEF_NOP_INSTR = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  // Stream format: count byte, 4*N little-endian data bytes, checksum byte.
  localparam int                     BYTES_PER_WORD = 4;
  localparam int                     BYTE_IDX_W     = 2;
  localparam logic [BYTE_IDX_W-1:0]  LAST_BYTE_IDX  = 2'd3;
  localparam logic [7:0]             COUNT_FULL     = 8'd0;  // count byte meaning "all 2^AW words"

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the loader byte stream (in_valid/in_data/in_ready) and the core fetch
// bus (rom_addr/instr).
//   master : stream producer / fetching core  (drives in_valid, in_data, rom_addr)
//   slave  : imem_loader                      (drives in_ready, instr)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] rom_addr;
  logic [31:0]   instr;

  modport master (
    output in_valid, in_data, rom_addr,
    input  in_ready, instr
  );

  modport slave (
    input  in_valid, in_data, rom_addr,
    output in_ready, instr
  );
endinterface

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// 2^AW x 32 instruction memory: one synchronous write port, one asynchronous
// read port.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write word address
//   i_wdata  : write data
//   i_raddr  : read word address
//   o_rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**AW];

  // NOTE: the array has no reset: contents must survive a core/loader reset,
  // and a reset port would stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program over a byte stream (count, little-endian words, 8-bit
// additive checksum), writes it into imem_ram, and releases the core reset
// only once the checksum matches.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : imem_loader_if.slave (byte stream in, fetch bus out)
//   cpu_rst_n  : registered active-low core reset, high only in RUN
//   load_done  : high in RUN
//   err        : high in ERROR (checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              AW        = 8,
  parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_loader_if.slave   bus,
  output logic           cpu_rst_n,
  output logic           load_done,
  output logic           err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW:0]           r_n;          // words in this load; AW+1 bits so 2^AW fits
  logic [AW:0]           r_word_cnt;   // words written so far, never wraps early
  logic [AW-1:0]         r_wr_addr;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [7:0]            r_sum;
  logic [23:0]           r_asm;        // bytes 0-2 of the word being assembled
  logic                  r_cpu_rst_n;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_start;      // accepted count byte (from IDLE or ERROR)
  logic                  w_we;         // byte 3 accepted: write the full word
  logic                  w_last_word;
  logic [AW:0]           w_count;
  logic [WORD_W-1:0]     w_wdata;
  logic [WORD_W-1:0]     w_rdata;

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_count     = (bus.in_data == COUNT_FULL) ? {1'b1, {AW{1'b0}}}
                                                   : (AW+1)'(bus.in_data);
  assign w_last_word = ((r_word_cnt + (AW+1)'(1)) == r_n);
  assign w_wdata     = {bus.in_data, r_asm};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_start     = 1'b0;
    w_we        = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_ERROR: begin
        // In ERROR the next byte is taken as a fresh count byte.
        if (bus.in_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid && (r_byte_idx == LAST_BYTE_IDX)) begin
          w_we = 1'b1;
          if (w_last_word) begin
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (bus.in_valid) begin
          w_state_nxt = (bus.in_data == r_sum) ? ST_RUN : ST_ERROR;
        end
      end
      ST_RUN: begin
        w_in_ready = 1'b0;  // program is live; stream is ignored
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load datapath: count, address, byte index, checksum, word assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_word_cnt <= '0;
      r_wr_addr  <= '0;
      r_byte_idx <= '0;
      r_sum      <= '0;
      r_asm      <= '0;
    end else if (w_start) begin
      r_n        <= w_count;
      r_word_cnt <= '0;
      r_wr_addr  <= '0;
      r_byte_idx <= '0;
      r_sum      <= '0;
      r_asm      <= '0;
    end else if ((r_state == ST_LOAD) && w_accept) begin
      r_sum      <= r_sum + bus.in_data;
      r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);  // wraps 3 -> 0 on the write
      case (r_byte_idx)
        2'd0:    r_asm[7:0]   <= bus.in_data;
        2'd1:    r_asm[15:8]  <= bus.in_data;
        2'd2:    r_asm[23:16] <= bus.in_data;
        default: ;  // byte 3 goes straight to memory with r_asm
      endcase
      if (w_we) begin
        r_wr_addr  <= r_wr_addr + AW'(1);
        r_word_cnt <= r_word_cnt + (AW+1)'(1);
      end
    end
  end

  // Core reset rises on the very edge that enters RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_state_nxt == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  imem_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_wdata),
    .i_raddr (bus.rom_addr),
    .o_rdata (w_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready = w_in_ready;
  assign bus.instr    = (r_state == ST_RUN) ? w_rdata : NOP_INSTR;
  assign cpu_rst_n    = r_cpu_rst_n;
  assign load_done    = (r_state == ST_RUN);
  assign err          = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader. Stimulus builds byte streams from word
// lists, updates a word-array memory model, and queues expected output
// snapshots; a monitor pops them on the falling edge and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst_n;
  logic load_done;
  logic err;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.AW(AW), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   instr;
    logic          crst;
    logic          done;
    logic          er;
    logic          rdy;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    n_writes = 0;

  // Reference memory: what each word must hold after the loads issued so far.
  logic [31:0] model_mem [DEPTH];

  // Observed write strobes into the array (actual value, not an expectation).
  always @(posedge clk) begin
    if (dut.u_ram.i_we === 1'b1) n_writes++;
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every queued snapshot at the falling edge
  // ---------------------------------------------------------------------------
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if (bus.instr !== e.instr || cpu_rst_n !== e.crst || load_done !== e.done ||
            err !== e.er || bus.in_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL %s addr=%h: got instr=%h cpu_rst_n=%b load_done=%b err=%b in_ready=%b; want instr=%h cpu_rst_n=%b load_done=%b err=%b in_ready=%b",
                   nm, e.addr, bus.instr, cpu_rst_n, load_done, err, bus.in_ready,
                   e.instr, e.crst, e.done, e.er, e.rdy);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic expect_out(input string name, input logic [AW-1:0] addr, input logic [31:0] ins,
                            input logic crst, input logic done, input logic er, input logic rdy);
    exp_t e;
    bus.rom_addr = addr;
    e.addr = addr; e.instr = ins; e.crst = crst; e.done = done; e.er = er; e.rdy = rdy;
    sb_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk); #1;
  endtask

  task automatic expect_run(input string name, input logic [AW-1:0] addr);
    expect_out(name, addr, model_mem[addr], 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_err(input string name);
    expect_out(name, AW'($urandom_range(0, DEPTH-1)), NOP, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic expect_idle(input string name);
    expect_out(name, AW'($urandom_range(0, DEPTH-1)), NOP, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: in_ready stayed %b for %0d cycles, want 1", bus.in_ready, waited);
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Sends count, words (little-endian) and checksum (+chk_off to corrupt it),
  // idling `gap` cycles after every byte. Every complete word lands in memory
  // whatever the checksum turns out to be.
  task automatic send_stream(input logic [31:0] words[$], input logic [7:0] chk_off, input int gap);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    send_byte(8'(words.size()));
    repeat (gap) begin @(posedge clk); #1; end
    for (int k = 0; k < words.size(); k++) begin
      for (int j = 0; j < 4; j++) begin
        b   = words[k][8*j +: 8];
        sum = sum + b;
        send_byte(b);
        repeat (gap) begin @(posedge clk); #1; end
      end
      model_mem[k] = words[k];
    end
    send_byte(sum + chk_off);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    expect_idle("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] w[$];
    int          n;
    int          waited;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rom_addr = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    #12;
    expect_out("reset_outputs", '0, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-word program, correct checksum E3
    w = '{32'h00500093};
    send_stream(w, 8'd0, 0);
    expect_out("one_word_run", 8'h00, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0);

    // Bad checksum E4, then recovery from ERROR with a correct stream
    do_reset();
    send_stream(w, 8'd1, 0);
    expect_out("bad_chk_err", 8'h00, NOP, 1'b0, 1'b0, 1'b1, 1'b1);
    w = '{32'h00A00113, 32'hDEADBEEF};
    send_stream(w, 8'd0, 0);
    expect_out("recover_w0", 8'h00, 32'h00A00113, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("recover_w1", 8'h01, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Full memory (count byte 00), word k = k
    do_reset();
    w.delete();
    for (int k = 0; k < DEPTH; k++) w.push_back(32'(k));
    n_writes = 0;
    send_stream(w, 8'd0, 0);
    expect_out("full_last", 8'hFF, 32'h000000FF, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("full_first", 8'h00, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_run("full_mid", 8'h80);
    check_val("full_write_count", n_writes, DEPTH);

    // Same single-word program with 3 idle cycles after every byte
    do_reset();
    w = '{32'h00500093};
    send_stream(w, 8'd0, 3);
    expect_out("gap_run", 8'h00, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("gap_keeps_w1", 8'h01, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset after the count and 3 data bytes, then a fresh full stream
    do_reset();
    send_byte(8'h01);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h50);
    do_reset();
    w = '{32'h12345678};
    send_stream(w, 8'd0, 0);
    expect_out("after_midreset", 8'h00, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stream activity while in RUN is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int c = 0; c < 10; c++) expect_run("run_ignores_input", 8'h00);
    bus.in_valid = 1'b0;
    expect_run("run_after_ignore_w0", 8'h00);
    expect_run("run_after_ignore_w2", 8'h02);

    // Randomized loads: optional corrupted stream first, then a good one
    for (int it = 0; it < 8; it++) begin
      do_reset();
      if ($urandom_range(0, 2) == 0) begin
        w.delete();
        n = $urandom_range(1, 12);
        for (int k = 0; k < n; k++) w.push_back($urandom);
        send_stream(w, 8'($urandom_range(1, 255)), $urandom_range(0, 2));
        expect_err("rand_bad_err");
      end
      w.delete();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) w.push_back($urandom);
      send_stream(w, 8'd0, $urandom_range(0, 2));
      for (int k = 0; k < n; k++) expect_run("rand_loaded", AW'(k));
      for (int k = 0; k < 3; k++) expect_run("rand_retained", AW'($urandom_range(0, DEPTH-1)));
    end

    // Let the monitor drain the scoreboard
    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter AW, 8, instruction-memory address width; depth is 2^AW words of 32 bits.
REQ-002 Parameter NOP_INSTR, 32'h00000013, word driven on instr while not in RUN.
REQ-003 clk  input  1  single system clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  loader byte-stream valid.
REQ-006 in_data  input  8  loader byte; consumed when in_valid && in_ready at a clk edge.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 rom_addr  input  AW  core fetch word address.
REQ-009 instr  output  32  fetched instruction to the core.
REQ-010 cpu_rst_n  output  1  active-low reset to the core; released only after a verified load.
REQ-011 load_done  output  1  high in RUN.
REQ-012 err  output  1  high in ERROR.

Function
REQ-013 Stream format SHALL be: count byte N (N=0 means 2^AW words), then 4*N data bytes forming words little-endian (first byte = bits 7:0), then one checksum byte.
REQ-014 Checksum SHALL be the 8-bit modulo-256 sum of all 4*N data bytes; count and checksum bytes are excluded.
REQ-015 FSM states SHALL be IDLE, LOAD, CHECK, RUN, ERROR.
REQ-016 IDLE: in_ready=1; an accepted byte latches N, clears the write address, byte index and running sum, then goes to LOAD.
REQ-017 LOAD: in_ready=1; bytes 0-2 of each word go to a 24-bit assembly register; on byte 3 the full word SHALL be written to mem[wr_addr] on that same edge, and wr_addr increments.
REQ-018 LOAD SHALL go to CHECK on the edge that writes word N; word count SHALL use an AW+1-bit counter so N=0 loads exactly 2^AW words with no early exit on address wrap.
REQ-019 CHECK: in_ready=1; an accepted byte equal to the sum goes to RUN, otherwise to ERROR.
REQ-020 RUN: in_ready=0; cpu_rst_n=1; load_done=1; stream input ignored.
REQ-021 ERROR: err=1; in_ready=1; an accepted byte SHALL be treated as a new count byte (same actions as IDLE) and go to LOAD, clearing err.
REQ-022 cpu_rst_n SHALL be a registered output, 0 in every state except RUN, rising on the edge that enters RUN.
REQ-023 instr SHALL be combinational: mem[rom_addr] in RUN, NOP_INSTR in all other states.
REQ-024 Cycles with in_valid=0 SHALL not change any state, counter or sum; gaps are allowed anywhere in the stream.
REQ-025 Words not written by the current load SHALL keep prior contents; no other memory write path exists.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state=IDLE, in_ready=1 after reset, cpu_rst_n=0, load_done=0, err=0, all counters, sum and assembly register to 0.
REQ-027 Reset mid-LOAD SHALL abandon the load; words already written stay in memory; the next stream restarts from a count byte.
REQ-028 The memory array SHALL NOT be reset.

Structure
REQ-029 State encoding, NOP_INSTR value and the stream-format constants SHALL live in the shared core package, next to the opcode constants.
REQ-030 The 2^AW x 32 array SHALL be one sub-module, imem_ram, with one synchronous write port and one asynchronous read port; the FSM, counters and checksum stay in imem_loader.

Verification
REQ-031 Stream 01,93,00,50,00,E3 -> RUN after 6 accepted bytes; cpu_rst_n=1; rom_addr=0 gives instr=32'h00500093.
REQ-032 Same stream with checksum E4 -> ERROR, err=1, cpu_rst_n=0, instr=32'h00000013; then a correct full stream -> RUN.
REQ-033 N=00 with 1024 data bytes, word k=k, correct checksum -> exactly 256 writes; rom_addr=FF gives 32'h000000FF; LOAD does not exit at address wrap.
REQ-034 Valid stream with in_valid deasserted for 3 cycles between every byte -> identical result to REQ-031.
REQ-035 rst_n pulsed low after 3 data bytes of the REQ-031 stream -> immediately IDLE, cpu_rst_n=0; a fresh full stream then reaches RUN.
REQ-036 In RUN, in_valid=1 with in_data=55 for 10 cycles -> in_ready=0, memory and state unchanged.
